// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: active-area decode, ROM image placement, background fill and blanking; 3-cycle latency, no backpressure.
// Defining VGA_TEST_PATTERN_EN replaces the image/background with 8 vertical colour bars.
module vga_pixel_pipe #(
    parameter int          H_START  = 217,
    parameter int          H_ACTIVE = 800,
    parameter int          V_START  = 28,
    parameter int          V_ACTIVE = 600,
    parameter int          IMG_X    = 368,
    parameter int          IMG_Y    = 268,
    parameter int          IMG_W    = 64,
    parameter int          IMG_H    = 64,
    parameter int          ADDR_W   = 12,
    parameter logic [15:0] BG_COLOR = 16'h0010
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [11:0]       Col_In,
    input  logic [11:0]       Row_In,
    input  logic              HSYNC_In,
    input  logic              VSYNC_In,
    output logic [ADDR_W-1:0] Rom_Addr,
    input  logic [15:0]       Rom_Data,
    output logic [4:0]        Red,
    output logic [5:0]        Green,
    output logic [4:0]        Blue,
    output logic              HSYNC_Out,
    output logic              VSYNC_Out,
    output logic              Frame_Start
);
    localparam int               LOG2_W  = $clog2(IMG_W);
    localparam logic signed [12:0] X_OFS   = 13'(H_START + IMG_X);
    localparam logic signed [12:0] Y_OFS   = 13'(V_START + IMG_Y);
    localparam logic signed [12:0] IMG_W_S = 13'(IMG_W);
    localparam logic signed [12:0] IMG_H_S = 13'(IMG_H);

    logic                     w_act;
    logic                     w_img;
    logic                     w_first;
    logic signed [12:0]       w_x;
    logic signed [12:0]       w_y;
    logic [ADDR_W-1:0]        w_addr;
    logic [15:0]              w_pix;

    logic                     r_act1, r_img1, r_first1;
    logic                     r_act2, r_img2, r_first2;
    logic [ADDR_W-1:0]        r_rom_addr;
    logic [15:0]              r_pix;
    logic                     r_first3;
    logic [2:0]               r_hs_dly;
    logic [2:0]               r_vs_dly;

    // Purely comparative decode: wrap and out-of-range counters fall out as blank.
    assign w_act = (Col_In >= 12'(H_START)) && (Col_In < 12'(H_START + H_ACTIVE)) &&
                   (Row_In >= 12'(V_START)) && (Row_In < 12'(V_START + V_ACTIVE));
    assign w_x   = $signed({1'b0, Col_In}) - X_OFS;
    assign w_y   = $signed({1'b0, Row_In}) - Y_OFS;
    assign w_img = w_act && (w_x >= 13'sd0) && (w_x < IMG_W_S) &&
                   (w_y >= 13'sd0) && (w_y < IMG_H_S);
    assign w_addr  = ADDR_W'((32'(w_y) << LOG2_W) + 32'(w_x));
    assign w_first = (Col_In == 12'(H_START)) && (Row_In == 12'(V_START));

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [11:0] w_hx;
    logic [2:0]  w_bar;
    logic [2:0]  r_bar1, r_bar2;

    assign w_hx = Col_In - 12'(H_START);

    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_hx >= 12'(k * BAR_W)) w_bar = 3'(k);
        end
    end

    function automatic logic [15:0] bar_color(input logic [2:0] b);
        case (b)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_bar1 <= 3'd0;
            r_bar2 <= 3'd0;
        end else begin
            r_bar1 <= w_bar;
            r_bar2 <= r_bar1;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_act1     <= 1'b0;
            r_img1     <= 1'b0;
            r_first1   <= 1'b0;
            r_rom_addr <= '0;
            r_act2     <= 1'b0;
            r_img2     <= 1'b0;
            r_first2   <= 1'b0;
            r_pix      <= 16'h0000;
            r_first3   <= 1'b0;
            r_hs_dly   <= 3'b111;
            r_vs_dly   <= 3'b111;
        end else begin
            r_act1     <= w_act;
            r_img1     <= w_img;
            r_first1   <= w_first;
`ifdef VGA_TEST_PATTERN_EN
            r_rom_addr <= '0;
`else
            r_rom_addr <= w_img ? w_addr : '0;
`endif
            // Stage 2 only waits out the ROM's one-cycle read latency.
            r_act2     <= r_act1;
            r_img2     <= r_img1;
            r_first2   <= r_first1;
            r_pix      <= w_pix;
            r_first3   <= r_first2;
            r_hs_dly   <= {r_hs_dly[1:0], HSYNC_In};
            r_vs_dly   <= {r_vs_dly[1:0], VSYNC_In};
        end
    end

    always_comb begin
        w_pix = 16'h0000;
        if (r_act2) begin
`ifdef VGA_TEST_PATTERN_EN
            w_pix = bar_color(r_bar2);
`else
            w_pix = r_img2 ? Rom_Data : BG_COLOR;
`endif
        end
    end

    assign Rom_Addr    = r_rom_addr;
    assign Red         = r_pix[15:11];
    assign Green       = r_pix[10:5];
    assign Blue        = r_pix[4:0];
    assign HSYNC_Out   = r_hs_dly[2];
    assign VSYNC_Out   = r_vs_dly[2];
    assign Frame_Start = r_first3;

endmodule
